// File: rtl/spi_pkg.sv
// Shared types and default parameters for the parametrised SPI master.
package spi_pkg;

  typedef enum logic [1:0] {IDLE, LEAD, XFER, TRAIL} spi_state_e;

  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_cfg_t;

  localparam int SPI_DATA_W = 8;
  localparam int SPI_NUM_CS = 1;
  localparam int SPI_DIV_W  = 8;

endpackage

// File: rtl/spi_clk_div.sv
// SCLK half-period divider: while enabled, tick is high on the last cycle of every
// H = load_val+1 cycles; load restarts the count and captures the period.
module spi_clk_div
  import spi_pkg::*;
#(
  parameter int DIV_W = SPI_DIV_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic [DIV_W-1:0] load_val,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] period;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      period <= '0;
    end else if (load) begin
      cnt    <= load_val;
      period <= load_val;
    end else if (en) begin
      if (cnt == '0) cnt <= period;
      else           cnt <= cnt - 1'b1;
    end
  end

  assign tick = en && (cnt == '0);

endmodule

// File: rtl/spi_master_param.sv
// Parametrised SPI master: DATA_W-bit words, NUM_CS selects, runtime CPOL/CPHA, SCLK half-period clk_div+1.
// Define SPI_MASTER_LSB_FIRST_EN to add the lsb_first port selecting per-transfer bit order.
module spi_master_param
  import spi_pkg::*;
#(
  parameter  int DATA_W   = SPI_DATA_W,
  parameter  int NUM_CS   = SPI_NUM_CS,
  parameter  int DIV_W    = SPI_DIV_W,
  localparam int CS_SEL_W = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                cpol,
  input  logic                cpha,
  input  logic [DIV_W-1:0]    clk_div,
  input  logic [CS_SEL_W-1:0] cs_sel,
  input  logic [DATA_W-1:0]   tx_data,
  output logic [DATA_W-1:0]   rx_data,
  output logic                busy,
  output logic                done,
  output logic                sclk,
  output logic                mosi,
  input  logic                miso,
`ifdef SPI_MASTER_LSB_FIRST_EN
  input  logic                lsb_first,
`endif
  output logic [NUM_CS-1:0]   cs_n
);

  localparam int EDGE_W = $clog2(2*DATA_W + 1);
  localparam logic [EDGE_W-1:0] EDGES     = EDGE_W'(2*DATA_W);
  localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(2*DATA_W - 1);

  spi_state_e        state, state_d;
  spi_cfg_t          cfg;
  logic [DATA_W-1:0] tx_sh;
  logic [DATA_W-1:0] rx_sh;
  logic [EDGE_W-1:0] edge_cnt;
  logic              tick;
  logic              start_ok;
  logic              edge_ev;
  logic              sample;
  logic              lsb_in;
  logic              lsb_q;

  function automatic logic head(input logic [DATA_W-1:0] v, input logic lsb);
    return lsb ? v[0] : v[DATA_W-1];
  endfunction

  function automatic logic [DATA_W-1:0] advance(input logic [DATA_W-1:0] v, input logic lsb);
    return lsb ? (v >> 1) : (v << 1);
  endfunction

  function automatic logic [DATA_W-1:0] capture(input logic [DATA_W-1:0] v, input logic b,
                                                input logic lsb);
    return lsb ? {b, v[DATA_W-1:1]} : {v[DATA_W-2:0], b};
  endfunction

`ifdef SPI_MASTER_LSB_FIRST_EN
  assign lsb_in = lsb_first;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        lsb_q <= 1'b0;
    else if (start_ok) lsb_q <= lsb_first;
  end
`else
  assign lsb_in = 1'b0;
  assign lsb_q  = 1'b0;
`endif

  spi_clk_div #(.DIV_W(DIV_W)) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (state != IDLE),
    .load     (start_ok),
    .load_val (clk_div),
    .tick     (tick)
  );

  // The LEAD tick produces the first leading edge; XFER ticks produce the rest,
  // and the XFER tick after the last edge closes the final half-period.
  assign edge_ev = tick && ((state == LEAD) || ((state == XFER) && (edge_cnt != EDGES)));
  assign sample  = ~edge_cnt[0] ^ cfg.cpha;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d  = state;
    start_ok = 1'b0;
    case (state)
      IDLE: begin
        if (start && (32'(cs_sel) < NUM_CS)) begin
          start_ok = 1'b1;
          state_d  = LEAD;
        end
      end
      LEAD:    if (tick) state_d = XFER;
      XFER:    if (tick && (edge_cnt == EDGES)) state_d = TRAIL;
      TRAIL:   if (tick) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg      <= '0;
      tx_sh    <= '0;
      rx_sh    <= '0;
      edge_cnt <= '0;
      rx_data  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sclk     <= 1'b0;
      mosi     <= 1'b0;
      cs_n     <= '1;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          sclk <= cpol;
          if (start_ok) begin
            cfg      <= '{cpol: cpol, cpha: cpha};
            cs_n     <= ~(NUM_CS'(1) << cs_sel);
            busy     <= 1'b1;
            edge_cnt <= '0;
            rx_sh    <= '0;
            // cpha=0 presents the first bit before the first edge; cpha=1 on it.
            if (cpha) begin
              mosi  <= 1'b0;
              tx_sh <= tx_data;
            end else begin
              mosi  <= head(tx_data, lsb_in);
              tx_sh <= advance(tx_data, lsb_in);
            end
          end
        end
        LEAD, XFER: begin
          if (edge_ev) begin
            sclk     <= ~sclk;
            edge_cnt <= edge_cnt + 1'b1;
            if (sample) begin
              rx_sh <= capture(rx_sh, miso, lsb_q);
            end else if (edge_cnt != LAST_EDGE) begin
              mosi  <= head(tx_sh, lsb_q);
              tx_sh <= advance(tx_sh, lsb_q);
            end
          end
        end
        TRAIL: begin
          sclk <= cfg.cpol;
          if (tick) begin
            done    <= 1'b1;
            busy    <= 1'b0;
            cs_n    <= '1;
            rx_data <= rx_sh;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_param.sv
// Self-checking bench for spi_master_param: SPI slave model plus a scoreboard of expected transfers.
module tb_spi_master_param;

  localparam int DATA_W   = 8;
  localparam int NUM_CS   = 5;
  localparam int DIV_W    = 8;
  localparam int CS_SEL_W = 3;

  logic                clk = 1'b0;
  logic                rst_n = 1'b1;
  logic                start = 1'b0;
  logic                cpol = 1'b0;
  logic                cpha = 1'b0;
  logic [DIV_W-1:0]    clk_div = '0;
  logic [CS_SEL_W-1:0] cs_sel = '0;
  logic [DATA_W-1:0]   tx_data = '0;
  logic [DATA_W-1:0]   rx_data;
  logic                busy, done, sclk, mosi, miso;
  logic [NUM_CS-1:0]   cs_n;
`ifdef SPI_MASTER_LSB_FIRST_EN
  logic                lsb_first = 1'b0;
`endif

  always #5 clk = ~clk;

  spi_master_param #(.DATA_W(DATA_W), .NUM_CS(NUM_CS), .DIV_W(DIV_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .cpol      (cpol),
    .cpha      (cpha),
    .clk_div   (clk_div),
    .cs_sel    (cs_sel),
    .tx_data   (tx_data),
    .rx_data   (rx_data),
    .busy      (busy),
    .done      (done),
    .sclk      (sclk),
    .mosi      (mosi),
    .miso      (miso),
`ifdef SPI_MASTER_LSB_FIRST_EN
    .lsb_first (lsb_first),
`endif
    .cs_n      (cs_n)
  );

  int n_checks = 0;
  int n_errs   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Slave model: reacts to the pins only, using the mode the bench programmed.
  logic              loopback = 1'b0;
  logic              s_pol = 1'b0, s_pha = 1'b0, s_miso = 1'b0;
  logic [DATA_W-1:0] s_word = '0, s_sh = '0, s_rx = '0;
  int                s_edges = 0, s_rises = 0;
  logic              cs_idle, cs_prev = 1'b1;

  assign cs_idle = &cs_n;
  assign miso    = loopback ? mosi : s_miso;

  always @(sclk or cs_idle) begin
    if (cs_prev && !cs_idle) begin
      s_sh = s_word; s_rx = '0; s_edges = 0; s_rises = 0;
      if (!s_pha) s_miso = s_sh[DATA_W-1];
    end else if (!cs_idle) begin
      s_edges++;
      if (sclk) s_rises++;
      if ((sclk != s_pol) ^ s_pha) begin
        s_rx = {s_rx[DATA_W-2:0], mosi};
      end else if (sclk != s_pol) begin
        s_miso = s_sh[DATA_W-1];
        s_sh   = s_sh << 1;
      end else begin
        s_sh   = s_sh << 1;
        s_miso = s_sh[DATA_W-1];
      end
    end
    cs_prev = cs_idle;
  end

  typedef struct {
    logic [DATA_W-1:0] rx;
    logic [DATA_W-1:0] mo;
    int                t0;
    int                lat;
    logic              pol;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc = 0;
  int   done_cnt = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (done === 1'b1) begin
      done_cnt++;
      check_eq("sb_pending", 32'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        check_eq("rx_data",    rx_data, mon_e.rx);
        check_eq("slave_mosi", s_rx, mon_e.mo);
        check_eq("latency",    cyc - mon_e.t0, mon_e.lat);
        check_eq("sclk_rises", s_rises, DATA_W);
        check_eq("done_busy",  busy, 0);
        check_eq("done_cs_n",  cs_n, {NUM_CS{1'b1}});
        check_eq("done_sclk",  sclk, mon_e.pol);
      end
    end
  end

  function automatic int xfer_lat(input logic [DIV_W-1:0] div);
    return 1 + (int'(div) + 1) * (2*DATA_W + 2);
  endfunction

  task automatic wait_done(input int limit);
    int n = 0;
    while (done !== 1'b1 && n < limit) begin
      @(negedge clk);
      n++;
    end
    check_eq("done_timeout", 32'(done === 1'b1), 1);
    @(negedge clk);
  endtask

  // Starts one transfer, checks the select pattern, then scrambles the inputs.
  task automatic kick(input logic pol, input logic pha, input logic [DIV_W-1:0] div,
                      input logic [CS_SEL_W-1:0] sel, input logic [DATA_W-1:0] tx,
                      input logic [DATA_W-1:0] rx_exp);
    exp_t e;
    logic [NUM_CS-1:0] m;
    @(negedge clk);
    cpol = pol; cpha = pha; s_pol = pol; s_pha = pha; s_word = rx_exp;
    repeat (2) @(negedge clk);
    check_eq("idle_sclk", sclk, pol);
    clk_div = div; cs_sel = sel; tx_data = tx; start = 1'b1;
    e.rx = rx_exp; e.mo = tx; e.t0 = cyc; e.lat = xfer_lat(div); e.pol = pol;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    m = '1;
    m[sel] = 1'b0;
    check_eq("busy_start", busy, 1);
    check_eq("cs_n_sel", cs_n, m);
    cpol = ~pol; cpha = ~pha; clk_div = '0; cs_sel = '0; tx_data = ~tx;
  endtask

  task automatic run_xfer(input logic pol, input logic pha, input logic [DIV_W-1:0] div,
                          input logic [CS_SEL_W-1:0] sel, input logic [DATA_W-1:0] tx,
                          input logic [DATA_W-1:0] rx_exp);
    kick(pol, pha, div, sel, tx, rx_exp);
    wait_done(xfer_lat(div) + 10);
  endtask

  initial begin
    int d0;
    int n;
    exp_t e;

    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_sclk", sclk, 0);
    check_eq("rst_mosi", mosi, 0);
    check_eq("rst_cs_n", cs_n, {NUM_CS{1'b1}});
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_rx",   rx_data, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    loopback = 1'b1;
    run_xfer(1'b0, 1'b0, 8'd1, 3'd0, 8'hA5, 8'hA5);
    loopback = 1'b0;
    run_xfer(1'b1, 1'b1, 8'd1, 3'd1, 8'h3C, 8'hC3);
    run_xfer(1'b0, 1'b1, 8'd2, 3'd4, 8'h81, 8'h7E);
    run_xfer(1'b1, 1'b0, 8'd0, 3'd2, 8'h81, 8'h7E);
    run_xfer(1'b0, 1'b0, 8'hFF, 3'd3, 8'h5A, 8'h96);

    // Out-of-range select must be ignored.
    @(negedge clk);
    d0 = done_cnt;
    cs_sel = 3'd5; tx_data = 8'h55; start = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("badsel_busy", busy, 0);
    check_eq("badsel_cs_n", cs_n, {NUM_CS{1'b1}});
    start = 1'b0;
    repeat (5) @(negedge clk);
    check_eq("badsel_done", done_cnt, d0);

    // Reset in the middle of XFER aborts without a done pulse.
    kick(1'b1, 1'b1, 8'd1, 3'd1, 8'h96, 8'h69);
    n = 0;
    while (s_edges < 5 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_eq("abort_edge", s_edges, 5);
    d0 = done_cnt;
    rst_n = 1'b0;
    #1;
    check_eq("abort_sclk", sclk, 0);
    check_eq("abort_mosi", mosi, 0);
    check_eq("abort_cs_n", cs_n, {NUM_CS{1'b1}});
    check_eq("abort_busy", busy, 0);
    check_eq("abort_rx",   rx_data, 0);
    sb.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check_eq("abort_no_done", done_cnt, d0);
    run_xfer(1'b1, 1'b1, 8'd0, 3'd0, 8'hE1, 8'h1E);

    // Back-to-back with start held; mid-transfer tx change goes to the second word only.
    @(negedge clk);
    cpol = 1'b0; cpha = 1'b0; s_pol = 1'b0; s_pha = 1'b0; s_word = 8'h3A;
    repeat (2) @(negedge clk);
    clk_div = 8'd0; cs_sel = 3'd3; tx_data = 8'hC5; start = 1'b1;
    e.rx = 8'h3A; e.mo = 8'hC5; e.t0 = cyc; e.lat = xfer_lat(8'd0); e.pol = 1'b0;
    sb.push_back(e);
    repeat (4) @(negedge clk);
    tx_data = 8'h11; s_word = 8'hE7;
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check_eq("b2b_first_done", 32'(done === 1'b1), 1);
    e.rx = 8'hE7; e.mo = 8'h11; e.t0 = cyc; e.lat = xfer_lat(8'd0); e.pol = 1'b0;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    check_eq("b2b_restart_busy", busy, 1);
    wait_done(xfer_lat(8'd0) + 10);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
